// File: rtl/alu_defs.sv
// Shared ALU definitions: opcode encodings and legality check.
// Also imported by the upstream decoder.
package alu_defs;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // True for the five opcodes the ALU implements.
    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_32_bit.sv
// Combinational 32-bit ALU. The overflow output is the signed overflow of the
// shared adder; the caller gates it to ADD/SUB and masks illegal opcodes.
module alu_32_bit
    import alu_defs::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  op_i,
    output logic [31:0] result_o,
    output logic        overflow_o
);

    logic        sub_sel;
    logic [31:0] b_eff;
    logic [31:0] sum;

    // One adder serves ADD and SUB (SUB adds the two's complement of b).
    always_comb begin
        sub_sel    = (op_i == OP_SUB);
        b_eff      = sub_sel ? ~b_i : b_i;
        sum        = a_i + b_eff + {31'd0, sub_sel};
        overflow_o = (a_i[31] == b_eff[31]) && (sum[31] != a_i[31]);
    end

    // Result select by opcode; unknown opcodes produce zero.
    always_comb begin
        case (op_i)
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_ADD:  result_o = sum;
            OP_SUB:  result_o = sum;
            OP_SLT:  result_o = ($signed(a_i) < $signed(b_i)) ? 32'd1 : 32'd0;
            default: result_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage elastic execute stage: operand register (S1), ALU, result
// register (S2), with full-throughput backpressure and saturating counters.
module alu_exec_stage
    import alu_defs::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] ovf_count
);

    logic             s1_valid_q;
    logic [31:0]      s1_a_q;
    logic [31:0]      s1_b_q;
    logic [2:0]       s1_op_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic             s2_valid_q;
    logic [31:0]      s2_result_q;
    logic             s2_zero_q;
    logic             s2_ovf_q;
    logic             s2_ill_q;
    logic [TAG_W-1:0] s2_tag_q;

    logic [31:0]      s2_result_d;
    logic             s2_zero_d;
    logic             s2_ovf_d;
    logic             s2_ill_d;

    logic [31:0]      alu_result;
    logic             alu_ovf;

    logic [CNT_W-1:0] op_cnt_q;
    logic [CNT_W-1:0] op_cnt_d;
    logic [CNT_W-1:0] ovf_cnt_q;
    logic [CNT_W-1:0] ovf_cnt_d;

    logic             s1_adv;
    logic             s2_adv;
    logic             out_fire;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign out_fire = s2_valid_q && out_ready;

    alu_32_bit u_alu (
        .a_i        (s1_a_q),
        .b_i        (s1_b_q),
        .op_i       (s1_op_q),
        .result_o   (alu_result),
        .overflow_o (alu_ovf)
    );

    // Illegal-op masking and overflow gating to ADD/SUB only.
    always_comb begin
        s2_ill_d    = !is_legal_op(s1_op_q);
        s2_result_d = s2_ill_d ? 32'd0 : alu_result;
        s2_ovf_d    = !s2_ill_d && ((s1_op_q == OP_ADD) || (s1_op_q == OP_SUB)) && alu_ovf;
        s2_zero_d   = (s2_result_d == 32'd0);
    end

    // S1 operand register: loads on an input handshake, empties when it drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s1_tag_q   <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q   <= in_a;
                s1_b_q   <= in_b;
                s1_op_q  <= in_op;
                s1_tag_q <= in_tag;
            end
        end
    end

    // S2 result register: takes the ALU output whenever the output slot frees up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_zero_q   <= 1'b0;
            s2_ovf_q    <= 1'b0;
            s2_ill_q    <= 1'b0;
            s2_tag_q    <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_result_q <= s2_result_d;
                s2_zero_q   <= s2_zero_d;
                s2_ovf_q    <= s2_ovf_d;
                s2_ill_q    <= s2_ill_d;
                s2_tag_q    <= s1_tag_q;
            end
        end
    end

    // Counter next state: clear wins over a same-cycle delivery.
    always_comb begin
        op_cnt_d  = op_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        if (clear_stats) begin
            op_cnt_d  = '0;
            ovf_cnt_d = '0;
        end else if (out_fire) begin
            op_cnt_d = sat_inc(op_cnt_q);
            if (s2_ovf_q) begin
                ovf_cnt_d = sat_inc(ovf_cnt_q);
            end
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_cnt_q  <= '0;
            ovf_cnt_q <= '0;
        end else begin
            op_cnt_q  <= op_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_result   = s2_result_q;
    assign out_zero     = s2_zero_q;
    assign out_overflow = s2_ovf_q;
    assign out_illegal  = s2_ill_q;
    assign out_tag      = s2_tag_q;
    assign op_count     = op_cnt_q;
    assign ovf_count    = ovf_cnt_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage. Two instances share all inputs: one
// with 16-bit counters and one with 2-bit counters for saturation.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [2:0]  in_op = '0;
    logic [3:0]  in_tag = '0;
    logic        out_ready = 1'b1;
    logic        clear_stats = 1'b0;

    logic        in_ready, in_ready2;
    logic        out_valid, out_valid2;
    logic [31:0] out_result, out_result2;
    logic        out_zero, out_zero2, out_overflow, out_overflow2, out_illegal, out_illegal2;
    logic [3:0]  out_tag, out_tag2;
    logic [15:0] op_count, ovf_count;
    logic [1:0]  op_count2, ovf_count2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        ill;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb[$];
    longint m_op16 = 0, m_ovf16 = 0, m_op2 = 0, m_ovf2 = 0;

    alu_exec_stage #(.TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_overflow(out_overflow), .out_illegal(out_illegal),
        .out_tag(out_tag), .clear_stats(clear_stats), .op_count(op_count),
        .ovf_count(ovf_count)
    );

    alu_exec_stage #(.TAG_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
        .out_zero(out_zero2), .out_overflow(out_overflow2), .out_illegal(out_illegal2),
        .out_tag(out_tag2), .clear_stats(clear_stats), .op_count(op_count2),
        .ovf_count(ovf_count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arithmetic on wide signed integers.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op, input logic [3:0] tag);
        exp_t   e;
        longint sa, sbv, s;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        s   = 0;
        e.tag = tag;
        e.ill = 1'b0;
        e.ovf = 1'b0;
        case (op)
            3'b000: e.res = a & b;
            3'b001: e.res = a | b;
            3'b010: begin
                s = sa + sbv;
                e.res = s[31:0];
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b110: begin
                s = sa - sbv;
                e.res = s[31:0];
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b111: e.res = (sa < sbv) ? 32'd1 : 32'd0;
            default: begin
                e.res = 32'd0;
                e.ill = 1'b1;
            end
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    function automatic longint sat(input longint v, input longint mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    // Monitor: compares the presented packet with the scoreboard head every
    // cycle it is valid, pops on handshake, tracks counters, records accepts.
    always @(negedge clk) begin
        exp_t e;
        logic fire, eovf;
        if (reset) begin
            sb.delete();
            m_op16 = 0; m_ovf16 = 0; m_op2 = 0; m_ovf2 = 0;
        end else begin
            check("op_count", op_count, m_op16);
            check("ovf_count", ovf_count, m_ovf16);
            check("op_count_w2", op_count2, m_op2);
            check("ovf_count_w2", ovf_count2, m_ovf2);
            check("twin_valid", out_valid2, out_valid);
            fire = 1'b0;
            eovf = 1'b0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: result %0h tag %0h with empty scoreboard", out_result, out_tag);
                end else begin
                    e = sb[0];
                    check("result", out_result, e.res);
                    check("zero", out_zero, e.zero);
                    check("overflow", out_overflow, e.ovf);
                    check("illegal", out_illegal, e.ill);
                    check("tag", out_tag, e.tag);
                    if (out_ready) begin
                        fire = 1'b1;
                        eovf = e.ovf;
                        void'(sb.pop_front());
                    end
                end
            end
            if (clear_stats) begin
                m_op16 = 0; m_ovf16 = 0; m_op2 = 0; m_ovf2 = 0;
            end else if (fire) begin
                m_op16 = sat(m_op16, 65535);
                m_op2  = sat(m_op2, 3);
                if (eovf) begin
                    m_ovf16 = sat(m_ovf16, 65535);
                    m_ovf2  = sat(m_ovf2, 3);
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_op, in_tag));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [3:0] tag);
        in_valid = 1'b1;
        in_a = a; in_b = b; in_op = op; in_tag = tag;
    endtask

    // Offer a packet until accepted; returns the number of stalled cycles.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [3:0] tag, output int waits);
        logic acc;
        waits = 0;
        drive(a, b, op, tag);
        acc = 1'b0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (!acc) begin
                waits++;
                if (waits > 200) begin
                    checks++; errors++;
                    $display("FAIL send_timeout: in_ready stuck %0d, expected 1", in_ready);
                    acc = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        check("drain_done", (sb.size() == 0 && !out_valid) ? 1 : 0, 1);
    endtask

    initial begin
        int w;
        logic r[4];
        // Reset state.
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_op_count", op_count, 0);
        tick();
        reset = 1'b0;
        tick();
        check("in_ready_after_reset", in_ready, 1);

        // Single ADD with latency check.
        out_ready = 1'b1;
        drive(32'h1, 32'h5, 3'b010, 4'd3);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_not_early", out_valid, 0);
        tick();
        @(negedge clk);
        check("latency_valid", out_valid, 1);
        check("add_result", out_result, 32'h6);
        tick();
        tick();
        check("single_op_count", op_count, 1);

        // Back-to-back stream, no stalls expected.
        send(32'hf0f0f0f0, 32'hffffffff, 3'b000, 4'd1, w); check("stream_stall0", w, 0);
        send(32'hffff0000, 32'h0000ffff, 3'b001, 4'd2, w); check("stream_stall1", w, 0);
        send(32'h5,        32'h3,        3'b110, 4'd3, w); check("stream_stall2", w, 0);
        send(32'h3,        32'h5,        3'b111, 4'd4, w); check("stream_stall3", w, 0);
        drain();

        // Overflow cases.
        send(32'h7fffffff, 32'h40000000, 3'b010, 4'd5, w);
        send(32'hbfffffff, 32'h40000001, 3'b110, 4'd6, w);
        send(32'h0000ffff, 32'h0000ffff, 3'b110, 4'd7, w);
        drain();
        check("ovf_count_two", ovf_count, 2);
        check("op_count_eight", op_count, 8);

        // Backpressure: four raw offers with out_ready low.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'h100 + i, 32'h1, 3'b010, 4'(8 + i));
            @(negedge clk);
            r[i] = in_ready;
            tick();
        end
        in_valid = 1'b0;
        check("bp_ready0", r[0], 1);
        check("bp_ready1", r[1], 1);
        check("bp_ready2", r[2], 0);
        check("bp_ready3", r[3], 0);
        check("bp_held", sb.size(), 2);
        tick();
        check("bp_still_full", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check("bp_ready_comb", in_ready, 1);
        drain();

        // Illegal opcode then a legal packet.
        send(32'hffffffff, 32'hffffffff, 3'b100, 4'd12, w);
        send(32'h2, 32'h3, 3'b010, 4'd13, w);
        drain();

        // Randomized traffic with random backpressure and occasional clears.
        for (int c = 0; c < 600; c++) begin
            out_ready   = ($urandom_range(0, 3) != 0);
            clear_stats = ($urandom_range(0, 40) == 0);
            in_valid    = $urandom_range(0, 1);
            in_a        = ($urandom_range(0, 3) == 0) ? 32'h7fffffff + $urandom_range(0, 2) : $urandom;
            in_b        = ($urandom_range(0, 3) == 0) ? in_a : $urandom;
            in_op       = 3'($urandom_range(0, 7));
            in_tag      = 4'($urandom);
            tick();
        end
        in_valid = 1'b0;
        clear_stats = 1'b0;
        out_ready = 1'b1;
        drain();

        // Saturation with 2-bit counters.
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        for (int i = 0; i < 5; i++) send(32'h7fffffff, 32'h1, 3'b010, 4'(i), w);
        drain();
        check("sat_op_w2", op_count2, 3);
        check("sat_ovf_w2", ovf_count2, 3);
        check("sat_op_w16", op_count, 5);
        check("sat_ovf_w16", ovf_count, 5);

        // Clear coinciding with a delivery.
        drive(32'h7fffffff, 32'h1, 3'b010, 4'd9);
        tick();
        in_valid = 1'b0;
        tick();
        clear_stats = 1'b1;
        @(negedge clk);
        check("clr_coincide_fire", (out_valid && out_ready) ? 1 : 0, 1);
        tick();
        clear_stats = 1'b0;
        @(negedge clk);
        check("clr_op_w2", op_count2, 0);
        check("clr_op_w16", op_count, 0);
        check("clr_ovf_w16", ovf_count, 0);

        // Asynchronous reset mid-stream.
        tick();
        drive(32'h10, 32'h1, 3'b010, 4'd1); tick();
        drive(32'h20, 32'h1, 3'b010, 4'd2); tick();
        drive(32'h30, 32'h1, 3'b010, 4'd3); tick();
        in_valid = 1'b0;
        check("pre_reset_valid", out_valid, 1);
        check("pre_reset_count", op_count, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset_valid", out_valid, 0);
        check("mid_reset_result", out_result, 0);
        check("mid_reset_op_count", op_count, 0);
        check("mid_reset_op_count_w2", op_count2, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_ready", in_ready, 1);
        send(32'h40, 32'h2, 3'b110, 4'd5, w);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time %0t exceeded, expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
